// File: rtl/snail_pkg.sv
// rtl/snail_pkg.sv - shared state encodings and debug names for the snail stream sequencer
package snail_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} seq_state_t;
  typedef enum logic {SAD, WAIT1} det_state_t;

  // Eight-character ASCII state name, for waveform viewers.
  function automatic logic [63:0] txstate(input seq_state_t s);
    case (s)
      IDLE:    txstate = "IDLE    ";
      SHIFT:   txstate = "SHIFT   ";
      FLUSH:   txstate = "FLUSH   ";
      default: txstate = "DONE    ";
    endcase
  endfunction

endpackage

// File: rtl/snail_pair_det.sv
// rtl/snail_pair_det.sv - registered-output Mealy "11" detector with synchronous clear
module snail_pair_det
  import snail_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  input  logic clr,
  output logic q
);

  det_state_t state, state_d;

  always_comb begin
    state_d = SAD;
    if (d) state_d = WAIT1;
  end

  // Q is the Mealy output registered, so it lags the second '1' by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SAD;
      q     <= 1'b0;
    end else if (clr) begin
      state <= SAD;
      q     <= 1'b0;
    end else begin
      state <= state_d;
      q     <= (state == WAIT1) && d;
    end
  end

endmodule

// File: rtl/snail_stream_sequencer.sv
// rtl/snail_stream_sequencer.sv - MSB-first word serialiser feeding the "11" detector, with match counting
// Optional first-match position output enabled by SNAIL_FIRST_POS_EN.
module snail_stream_sequencer
  import snail_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic             bit_out,
  output logic             match,
`ifdef SNAIL_FIRST_POS_EN
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] first_pos
`else
  output logic [CNT_W-1:0] match_cnt
`endif
);

  seq_state_t       state, state_d;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] idx;
  logic             accept;
  logic             counting;

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    bit_out = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy    = 1'b1;
        bit_out = shreg[WIDTH-1];
        if (idx == CNT_W'(WIDTH - 1)) state_d = FLUSH;
      end
      FLUSH: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      default: begin
        done    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  assign counting = (state == SHIFT) || (state == FLUSH);

  snail_pair_det u_det (
    .clk (clk),
    .rst (rst),
    .d   (bit_out),
    .clr (accept),
    .q   (match)
  );

  // idx keeps counting into FLUSH, so idx-1 is always the position of the bit behind a live match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      idx       <= '0;
      match_cnt <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        shreg     <= din;
        idx       <= '0;
        match_cnt <= '0;
      end else begin
        if (state == SHIFT) begin
          shreg <= shreg << 1;
          idx   <= idx + CNT_W'(1);
        end
        if (counting && match) match_cnt <= match_cnt + CNT_W'(1);
      end
    end
  end

`ifdef SNAIL_FIRST_POS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_pos <= '1;
    end else if (accept) begin
      first_pos <= '1;
    end else if (counting && match && (first_pos == '1)) begin
      first_pos <= idx - CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_snail_stream_sequencer.sv
// tb/tb_snail_stream_sequencer.sv - directed self-checking bench for snail_stream_sequencer (WIDTH=8)
module tb_snail_stream_sequencer;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             busy, done, bit_out, match;
  logic [CNT_W-1:0] match_cnt;
`ifdef SNAIL_FIRST_POS_EN
  logic [CNT_W-1:0] first_pos;
`endif

  int checks = 0;
  int failures = 0;

  snail_stream_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .din       (din),
    .busy      (busy),
    .done      (done),
    .bit_out   (bit_out),
    .match     (match),
`ifdef SNAIL_FIRST_POS_EN
    .match_cnt (match_cnt),
    .first_pos (first_pos)
`else
    .match_cnt (match_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Accept in cycle 0, then watch cycles 1.. at negedges until done or budget.
  task automatic run_word(input logic [WIDTH-1:0] w, input int exp_cnt, input string tag);
    int cyc;
    int nmatch;
    int done_cyc;
    nmatch = 0;
    done_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    din   = w;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check({tag, "_busy1"}, busy, 1);
    while (done_cyc < 0 && cyc < 20) begin
      if (match) nmatch++;
      if (done) done_cyc = cyc;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, "_done_cyc"}, done_cyc, WIDTH + 2);
    check({tag, "_cnt"}, match_cnt, exp_cnt);
    check({tag, "_pulses"}, nmatch, exp_cnt);
  endtask

  initial begin
    int ndone;
    int first_done;
    int nmatch;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bit_out", bit_out, 0);
    check("rst_match", match, 0);
    check("rst_cnt", match_cnt, 0);
    rst = 1'b0;

    run_word(8'b1100_0000, 1, "w_c0");
    @(negedge clk);
    check("hold_cnt_idle", match_cnt, 1);
    check("idle_busy", busy, 0);
    run_word(8'hFF, 7, "w_ff");
    run_word(8'hAA, 0, "w_aa");
    run_word(8'h01, 0, "w_01");
    run_word(8'h80, 0, "w_80");

    // Second start during SHIFT must be ignored entirely.
    ndone = 0;
    first_done = -1;
    nmatch = 0;
    @(negedge clk);
    start = 1'b1;
    din   = 8'b1100_0000;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      if (match) nmatch++;
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = cyc;
      end
      start = (cyc == 3);
      din   = (cyc == 3) ? 8'hFF : 8'h00;
      @(negedge clk);
    end
    start = 1'b0;
    check("ign_ndone", ndone, 1);
    check("ign_done_cyc", first_done, WIDTH + 2);
    check("ign_cnt", match_cnt, 1);
    check("ign_pulses", nmatch, 1);

    // Asynchronous reset in the middle of a word.
    @(negedge clk);
    start = 1'b1;
    din   = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_cnt", match_cnt, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cnt", match_cnt, 0);
    check("mid_rst_bit_out", bit_out, 0);
    check("mid_rst_match", match, 0);
    @(negedge clk);
    rst = 1'b0;
    run_word(8'hFF, 7, "post_rst_ff");

`ifdef SNAIL_FIRST_POS_EN
    run_word(8'b0110_0000, 1, "fp_60");
    check("fp_60_pos", first_pos, 2);
    run_word(8'h00, 0, "fp_00");
    check("fp_00_pos", first_pos, 15);
    run_word(8'b0000_0011, 1, "fp_03");
    check("fp_03_pos", first_pos, 7);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
